alu_share_arb: RTL and testbench
================================

ALU_SHARE_ARB -- requirements
Module: alu_share_arb

Interface
REQ-001 SHALL have parameter NREQ, default 2, meaning number of requesters (fixed at 2 for this revision).
REQ-002 SHALL have port clk  in  1  rising-edge clock; the one clock.
REQ-003 SHALL have port reset_n  in  1  synchronous active-low reset.
REQ-004 SHALL have ports reqN_valid  in  1  requester N (N=0,1) has an operation pending.
REQ-005 SHALL have ports reqN_ready  out  1  pulses high in the cycle requester N's operation is accepted.
REQ-006 SHALL have ports reqN_op  in  2  00 ADD, 01 SUB, 10 SLT (signed), 11 SLTU (unsigned).
REQ-007 SHALL have ports reqN_a, reqN_b  in  32  operands.
REQ-008 SHALL have ports rspN_valid  out  1  result for requester N available.
REQ-009 SHALL have ports rspN_data  out  32  result.
REQ-010 SHALL have ports rspN_ready  in  1  requester N consumes the result.

Function
REQ-011 SHALL share one 33-bit add/subtract datapath between both requesters; one operation in flight at a time.
REQ-012 SHALL use FSM states IDLE, EXEC, RESP.
REQ-013 IDLE: if any reqN_valid, grant one, assert its reqN_ready for exactly that cycle, latch op/a/b/owner, go EXEC; else stay IDLE.
REQ-014 Arbitration SHALL be round-robin: with both valid, grant the requester not granted last; pointer after reset favours requester 0.
REQ-015 EXEC: compute and register the result and go RESP; one cycle.
REQ-016 RESP: assert rsp_valid of owner only, hold rsp_data stable until rspN_ready is high; in that cycle return to IDLE.
REQ-017 Accept at edge k -> rsp_valid high from edge k+2; minimum 3 cycles per operation; no new grant while in EXEC or RESP.
REQ-018 Diff SHALL be {A[31],A} - {B[31],B} for SUB/SLT and {1'b0,A} - {1'b0,B} for SLTU; ADD uses A+B truncated to 32 bits.
REQ-019 SLT result SHALL be 1 iff Diff[31] XOR ovf, ovf = (A[31]!=B[31]) & (Diff[31]!=A[31]); zero-extended to 32 bits.
REQ-020 SLTU result SHALL be Diff[32] (borrow), zero-extended.
REQ-021 ADD/SUB SHALL wrap modulo 2^32; no overflow flag is exported.
REQ-022 rspN_ready while rspN_valid low SHALL be ignored; reqN_valid deasserted without ready SHALL simply withdraw the request.
REQ-023 rsp_data of the non-owner SHALL read 0.

Reset
REQ-024 When reset_n is low at a rising edge: state IDLE, RR pointer favours 0, all ready/valid low, result and operand registers 0.
REQ-025 Reset mid-operation SHALL drop the in-flight operation with no response issued.

Structure
REQ-026 Package alu_pkg SHALL hold the op-code enum (OP_ADD, OP_SUB, OP_SLT, OP_SLTU) and the FSM state enum.
REQ-027 The arithmetic SHALL be one combinational sub-module alu_core (op, a, b -> 32-bit result); FSM, arbiter and registers stay in alu_share_arb.

Verification
REQ-028 Req0 SLT a=0xFFFFFFFF b=0x00000001 -> rsp0_data=1 two cycles after accept; SLTU same operands -> 0.
REQ-029 Req1 SLT a=0x80000000 b=0x7FFFFFFF (overflow case) -> 1; a=0x7FFFFFFF b=0x80000000 -> 0.
REQ-030 Both valid continuously, 4 ops each -> grants alternate 0,1,0,1..., first grant 0 after reset.
REQ-031 rsp0_ready held low 5 cycles -> rsp0_valid and data stable, req1 not granted until rsp0 consumed.
REQ-032 ADD 0xFFFFFFFF+1 -> 0; SUB 0 - 1 -> 0xFFFFFFFF.
REQ-033 reset_n low during EXEC -> no rsp_valid, next grant favours requester 0.

Source files
------------

// File: rtl/alu_pkg.sv
// alu_pkg: shared op-code and FSM state types for the shared ALU arbiter
package alu_pkg;
   typedef enum logic [1:0] {OP_ADD, OP_SUB, OP_SLT, OP_SLTU} op_t;
   typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
endpackage

// File: rtl/alu_core.sv
// alu_core: single 33-bit adder serving ADD, SUB, signed and unsigned compare
import alu_pkg::*;
module alu_core (
   input  op_t         op,
   input  logic [31:0] a,
   input  logic [31:0] b,
   output logic [31:0] res
);
   logic        sx;
   logic        sub;
   logic [32:0] ax;
   logic [32:0] bx;
   logic [32:0] diff;
   logic        ovf;
   // sign-extend except for SLTU, subtract by adding the inverted operand plus one
   always_comb begin
      sx   = op != OP_SLTU;
      sub  = op != OP_ADD;
      ax   = {sx & a[31], a};
      bx   = {sx & b[31], b};
      diff = ax + (sub ? ~bx : bx) + {32'b0, sub};
      ovf  = (a[31] != b[31]) & (diff[31] != a[31]);
      res  = op == OP_SLT  ? {31'b0, diff[31] ^ ovf} :
             op == OP_SLTU ? {31'b0, diff[32]} : diff[31:0];
   end
endmodule

// File: rtl/alu_share_arb.sv
// alu_share_arb: round-robin sharing of one ALU between two requesters
import alu_pkg::*;
module alu_share_arb #(
   parameter int NREQ = 2
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        req0_valid,
   output logic        req0_ready,
   input  logic [1:0]  req0_op,
   input  logic [31:0] req0_a,
   input  logic [31:0] req0_b,
   output logic        rsp0_valid,
   output logic [31:0] rsp0_data,
   input  logic        rsp0_ready,
   input  logic        req1_valid,
   output logic        req1_ready,
   input  logic [1:0]  req1_op,
   input  logic [31:0] req1_a,
   input  logic [31:0] req1_b,
   output logic        rsp1_valid,
   output logic [31:0] rsp1_data,
   input  logic        rsp1_ready
);
   localparam int OW = $clog2(NREQ);
   state_t        state;
   logic          prio;
   logic [OW-1:0] owner;
   op_t           op_r;
   logic [31:0]   a_r;
   logic [31:0]   b_r;
   logic [31:0]   res_r;
   logic [31:0]   res;
   logic          any;
   logic          grant;
   logic          done;
   alu_core u_core (.op(op_r), .a(a_r), .b(b_r), .res(res));
   // grant decision, handshakes and owner-only response outputs
   always_comb begin
      any        = req0_valid | req1_valid;
      grant      = (req0_valid & req1_valid) ? prio : req1_valid;
      req0_ready = reset_n & state == IDLE & any & ~grant;
      req1_ready = reset_n & state == IDLE & any & grant;
      rsp0_valid = state == RESP & owner == '0;
      rsp1_valid = state == RESP & owner != '0;
      rsp0_data  = rsp0_valid ? res_r : 32'b0;
      rsp1_data  = rsp1_valid ? res_r : 32'b0;
      done       = (rsp0_valid & rsp0_ready) | (rsp1_valid & rsp1_ready);
   end
   // FSM, round-robin pointer and operand/result registers
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state <= IDLE;
         prio  <= 1'b0;
         owner <= '0;
         op_r  <= OP_ADD;
         a_r   <= 32'b0;
         b_r   <= 32'b0;
         res_r <= 32'b0;
      end else begin
         state <= state == IDLE ? (any ? EXEC : IDLE) : state == EXEC ? RESP : (done ? IDLE : RESP);
         if (state == IDLE && any) begin
            owner <= grant;
            prio  <= ~grant;
            op_r  <= op_t'(grant ? req1_op : req0_op);
            a_r   <= grant ? req1_a : req0_a;
            b_r   <= grant ? req1_b : req0_b;
         end
         if (state == EXEC) res_r <= res;
      end
   end
endmodule

// File: tb/tb_alu_share_arb.sv
// tb_alu_share_arb: directed self-checking bench for alu_share_arb
module tb_alu_share_arb;
   logic        clk = 1'b0;
   logic        reset_n;
   logic        req0_valid, req0_ready, rsp0_valid, rsp0_ready;
   logic        req1_valid, req1_ready, rsp1_valid, rsp1_ready;
   logic [1:0]  req0_op, req1_op;
   logic [31:0] req0_a, req0_b, req1_a, req1_b, rsp0_data, rsp1_data;
   int          cmp = 0;
   int          errs = 0;

   alu_share_arb #(.NREQ(2)) dut (
      .clk(clk), .reset_n(reset_n),
      .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
      .req0_a(req0_a), .req0_b(req0_b),
      .rsp0_valid(rsp0_valid), .rsp0_data(rsp0_data), .rsp0_ready(rsp0_ready),
      .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
      .req1_a(req1_a), .req1_b(req1_b),
      .rsp1_valid(rsp1_valid), .rsp1_data(rsp1_data), .rsp1_ready(rsp1_ready)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      cmp++;
      assert (obs === exp) else begin
         errs++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic set_req(input int n, input logic v, input logic [1:0] op,
                          input logic [31:0] a, input logic [31:0] b);
      if (n == 0) begin
         req0_valid = v; req0_op = op; req0_a = a; req0_b = b;
      end else begin
         req1_valid = v; req1_op = op; req1_a = a; req1_b = b;
      end
   endtask

   // one isolated operation on requester n, starting from IDLE, with latency checks
   task automatic do_op(input string tag, input int n, input logic [1:0] op,
                        input logic [31:0] a, input logic [31:0] b, input logic [31:0] exp);
      @(negedge clk);
      set_req(n, 1'b1, op, a, b);
      #1;
      chk({tag, "_ready"}, n == 0 ? req0_ready : req1_ready, 1);
      chk({tag, "_other_ready"}, n == 0 ? req1_ready : req0_ready, 0);
      @(negedge clk);
      set_req(n, 1'b0, op, a, b);
      #1;
      chk({tag, "_exec_valid"}, n == 0 ? rsp0_valid : rsp1_valid, 0);
      @(negedge clk);
      #1;
      chk({tag, "_rsp_valid"}, n == 0 ? rsp0_valid : rsp1_valid, 1);
      chk({tag, "_data"}, n == 0 ? rsp0_data : rsp1_data, exp);
      chk({tag, "_other_valid"}, n == 0 ? rsp1_valid : rsp0_valid, 0);
      chk({tag, "_other_data"}, n == 0 ? rsp1_data : rsp0_data, 0);
      @(negedge clk);
      #1;
      chk({tag, "_consumed"}, n == 0 ? rsp0_valid : rsp1_valid, 0);
   endtask

   initial begin
      reset_n = 1'b0;
      set_req(0, 1'b1, 2'b00, 32'd0, 32'd0);
      set_req(1, 1'b0, 2'b00, 32'd0, 32'd0);
      rsp0_ready = 1'b1;
      rsp1_ready = 1'b1;
      repeat (2) @(negedge clk);
      #1;
      chk("rst_ready0", req0_ready, 0);
      chk("rst_ready1", req1_ready, 0);
      chk("rst_rsp0_valid", rsp0_valid, 0);
      chk("rst_rsp1_valid", rsp1_valid, 0);
      chk("rst_rsp0_data", rsp0_data, 0);
      chk("rst_rsp1_data", rsp1_data, 0);
      req0_valid = 1'b0;
      reset_n = 1'b1;

      do_op("slt0",   0, 2'b10, 32'hFFFF_FFFF, 32'h0000_0001, 32'd1);
      do_op("sltu0",  0, 2'b11, 32'hFFFF_FFFF, 32'h0000_0001, 32'd0);
      do_op("slt1a",  1, 2'b10, 32'h8000_0000, 32'h7FFF_FFFF, 32'd1);
      do_op("slt1b",  1, 2'b10, 32'h7FFF_FFFF, 32'h8000_0000, 32'd0);
      do_op("add_wr", 0, 2'b00, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000);
      do_op("sub_wr", 1, 2'b01, 32'h0000_0000, 32'h0000_0001, 32'hFFFF_FFFF);
      do_op("sltu1",  1, 2'b11, 32'h0000_0001, 32'hFFFF_FFFF, 32'd1);
      do_op("add",    0, 2'b00, 32'h1234_5678, 32'h1111_1111, 32'h2345_6789);
      do_op("slt_eq", 0, 2'b10, 32'h8000_0000, 32'h8000_0000, 32'd0);

      // round robin with both requesters continuously valid, fresh from reset
      @(negedge clk);
      reset_n = 1'b0;
      @(negedge clk);
      reset_n = 1'b1;
      set_req(0, 1'b1, 2'b00, 32'd10, 32'd20);
      set_req(1, 1'b1, 2'b01, 32'd10, 32'd20);
      for (int i = 0; i < 8; i++) begin
         #1;
         chk($sformatf("rr%0d_ready0", i), req0_ready, (i % 2) == 0);
         chk($sformatf("rr%0d_ready1", i), req1_ready, (i % 2) == 1);
         @(negedge clk);
         #1;
         chk($sformatf("rr%0d_exec_ready", i), req0_ready | req1_ready, 0);
         @(negedge clk);
         #1;
         if (i % 2 == 0) begin
            chk($sformatf("rr%0d_rsp0", i), rsp0_data, 32'd30);
            chk($sformatf("rr%0d_rsp1_valid", i), rsp1_valid, 0);
         end else begin
            chk($sformatf("rr%0d_rsp1", i), rsp1_data, 32'hFFFF_FFF6);
            chk($sformatf("rr%0d_rsp0_valid", i), rsp0_valid, 0);
         end
         @(negedge clk);
      end
      set_req(0, 1'b0, 2'b00, 32'd0, 32'd0);
      set_req(1, 1'b0, 2'b00, 32'd0, 32'd0);

      // response back-pressure: owner holds, other requester is not granted
      @(negedge clk);
      rsp0_ready = 1'b0;
      set_req(0, 1'b1, 2'b00, 32'd3, 32'd4);
      #1;
      chk("bp_ready0", req0_ready, 1);
      @(negedge clk);
      set_req(0, 1'b0, 2'b00, 32'd0, 32'd0);
      set_req(1, 1'b1, 2'b01, 32'd5, 32'd3);
      @(negedge clk);
      for (int i = 0; i < 5; i++) begin
         #1;
         chk($sformatf("bp%0d_valid", i), rsp0_valid, 1);
         chk($sformatf("bp%0d_data", i), rsp0_data, 32'd7);
         chk($sformatf("bp%0d_ready1", i), req1_ready, 0);
         @(negedge clk);
      end
      rsp0_ready = 1'b1;
      @(negedge clk);
      #1;
      chk("bp_after_valid0", rsp0_valid, 0);
      chk("bp_after_ready1", req1_ready, 1);
      @(negedge clk);
      set_req(1, 1'b0, 2'b00, 32'd0, 32'd0);
      @(negedge clk);
      #1;
      chk("bp_rsp1", rsp1_data, 32'd2);
      @(negedge clk);

      // reset during EXEC drops the operation and restores priority to requester 0
      @(negedge clk);
      set_req(0, 1'b1, 2'b00, 32'd1, 32'd1);
      #1;
      chk("mr_ready0", req0_ready, 1);
      @(negedge clk);
      set_req(0, 1'b0, 2'b00, 32'd0, 32'd0);
      reset_n = 1'b0;
      @(negedge clk);
      reset_n = 1'b1;
      #1;
      chk("mr_rsp0_valid", rsp0_valid, 0);
      chk("mr_rsp1_valid", rsp1_valid, 0);
      @(negedge clk);
      #1;
      chk("mr_rsp0_valid_late", rsp0_valid, 0);
      set_req(0, 1'b1, 2'b00, 32'd6, 32'd7);
      set_req(1, 1'b1, 2'b00, 32'd8, 32'd9);
      #1;
      chk("mr_grant0", req0_ready, 1);
      chk("mr_grant1", req1_ready, 0);
      @(negedge clk);
      set_req(0, 1'b0, 2'b00, 32'd0, 32'd0);
      set_req(1, 1'b0, 2'b00, 32'd0, 32'd0);
      @(negedge clk);
      #1;
      chk("mr_rsp0_data", rsp0_data, 32'd13);
      @(negedge clk);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, errs);
      $finish;
   end
endmodule
